// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART word loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_POINT = 8;
  localparam int unsigned TIMEOUT_BITS = 160;

  // Sys_clk cycles per oversample tick, floored, never below 1.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OVERSAMPLE);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, 16x oversample tick generator and RX FSM.
// `enable` low forces the FSM idle and drops any partial byte.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       enable,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frameerror_pulse,
  output logic       busy
);

  localparam int unsigned BaudDiv = baud_div(CLK_HZ, BAUD);
  localparam int unsigned DivW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [3:0]  SampleAt = 4'(SAMPLE_POINT);
  localparam logic [3:0]  LastTick = 4'(OVERSAMPLE - 1);

  logic            rx_meta, rx_sync, rx_prev;
  logic            fall;
  logic [DivW-1:0] div_cnt_q;
  logic            tick;
  rx_state_e       state_q, state_d;
  logic [3:0]      sample_cnt_q, sample_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_ok, byte_bad;

  assign fall = rx_prev & ~rx_sync;
  assign tick = (div_cnt_q == DivW'(BaudDiv - 1));
  assign busy = (state_q != RxIdle);

  // Two-flop synchroniser plus edge-detect history; idle-high reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Tick divider runs only while a frame is in progress.
  always_ff @(posedge sys_clk) begin
    if (rst || state_q == RxIdle || tick) div_cnt_q <= '0;
    else                                  div_cnt_q <= div_cnt_q + 1'b1;
  end

  // Next-state logic; the stop bit is judged mid-bit so back-to-back frames are caught.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_ok      = 1'b0;
    byte_bad     = 1'b0;
    if (!enable) begin
      state_d = RxIdle;
    end else begin
      unique case (state_q)
        RxIdle: begin
          if (fall) begin
            state_d      = RxStart;
            sample_cnt_d = '0;
          end
        end
        RxStart: begin
          if (tick) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (sample_cnt_q == SampleAt && rx_sync) begin
              state_d = RxIdle;  // false start
            end else if (sample_cnt_q == LastTick) begin
              state_d   = RxData;
              bit_idx_d = '0;
            end
          end
        end
        RxData: begin
          if (tick) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (sample_cnt_q == SampleAt) shreg_d = {rx_sync, shreg_q[7:1]};
            if (sample_cnt_q == LastTick) begin
              bit_idx_d = bit_idx_q + 1'b1;
              if (bit_idx_q == 3'd7) state_d = RxStop;
            end
          end
        end
        RxStop: begin
          if (tick) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (sample_cnt_q == SampleAt) begin
              state_d  = RxIdle;
              byte_ok  = rx_sync;
              byte_bad = ~rx_sync;
            end
          end
        end
        default: state_d = RxIdle;
      endcase
    end
  end

  // FSM state and registered byte outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q          <= RxIdle;
      sample_cnt_q     <= '0;
      bit_idx_q        <= '0;
      shreg_q          <= '0;
      byte_valid       <= 1'b0;
      byte_data        <= '0;
      frameerror_pulse <= 1'b0;
    end else begin
      state_q          <= state_d;
      sample_cnt_q     <= sample_cnt_d;
      bit_idx_q        <= bit_idx_d;
      shreg_q          <= shreg_d;
      byte_valid       <= byte_ok;
      frameerror_pulse <= byte_bad;
      if (byte_ok) byte_data <= shreg_q;
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// UART word loader: packs received bytes into 32-bit little-endian words and issues one
// write strobe per word with an auto-incrementing address.
// Optional macro UART_WORD_LOADER_TIMEOUT_EN discards a partial word after a long idle gap.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_cnt,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              busy,
  output logic              frameerror
);

  localparam logic [ADDR_W:0] CntMax = {1'b1, {ADDR_W{1'b0}}};

  logic              ferr_pulse;
  logic              load_en_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_buf_q;
  logic [ADDR_W-1:0] addr_q;
  logic              gap_expired;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .rx               (rx),
    .enable           (load_en),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .frameerror_pulse (ferr_pulse),
    .busy             (busy)
  );

`ifdef UART_WORD_LOADER_TIMEOUT_EN
  localparam int unsigned GapLimit = TIMEOUT_BITS * OVERSAMPLE * baud_div(CLK_HZ, BAUD);
  localparam int unsigned GapW     = $clog2(GapLimit + 1);

  logic [GapW-1:0] gap_cnt_q;

  // Idle-gap counter, armed only while a partial word is pending and no frame is active.
  always_ff @(posedge sys_clk) begin
    if (rst || !load_en || busy || byte_valid || byte_idx_q == 2'd0) gap_cnt_q <= '0;
    else if (!gap_expired)                                            gap_cnt_q <= gap_cnt_q + 1'b1;
  end

  assign gap_expired = (gap_cnt_q == GapW'(GapLimit));
`else
  assign gap_expired = 1'b0;
`endif

  // Word assembly, write strobe, address/count and sticky frame error.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      load_en_q  <= 1'b0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      addr_q     <= '0;
      word_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frameerror <= 1'b0;
    end else begin
      load_en_q <= load_en;
      wr_en     <= 1'b0;
      if (load_en && !load_en_q) frameerror <= 1'b0;
      else if (ferr_pulse)       frameerror <= 1'b1;

      if (!load_en) begin
        byte_idx_q <= '0;
        addr_q     <= '0;
        word_cnt   <= '0;
      end else begin
        // Bookkeeping lands the cycle after the strobe so wr_addr shows the old address.
        if (wr_en) begin
          addr_q     <= addr_q + 1'b1;
          byte_idx_q <= '0;
          if (word_cnt != CntMax) word_cnt <= word_cnt + 1'b1;
        end
        if (ferr_pulse || gap_expired) begin
          byte_idx_q <= '0;  // resync word boundary
        end else if (byte_valid) begin
          case (byte_idx_q)
            2'd0:    word_buf_q[7:0]   <= byte_data;
            2'd1:    word_buf_q[15:8]  <= byte_data;
            2'd2:    word_buf_q[23:16] <= byte_data;
            default: begin
              wr_en   <= 1'b1;
              wr_data <= {byte_data, word_buf_q};
              wr_addr <= addr_q;
            end
          endcase
          if (byte_idx_q != 2'd3) byte_idx_q <= byte_idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: table-driven word stream plus hand-written
// corner sequences, with a write scoreboard fed as bytes are driven.
module tb_uart_word_loader;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned ADDR_W = 4;
  localparam int          BIT_CLKS = 16;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_rec_t;

  logic              sys_clk = 1'b0;
  logic              rst     = 1'b1;
  logic              rx      = 1'b1;
  logic              load_en = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_cnt;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              busy;
  logic              frameerror;

  int      checks   = 0;
  int      errors   = 0;
  int      bv_count = 0;
  wr_rec_t exp_q[$];
  wr_rec_t vecs[17];

  uart_word_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .ADDR_W (ADDR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .rx         (rx),
    .load_en    (load_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_cnt   (word_cnt),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .busy       (busy),
    .frameerror (frameerror)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the scoreboard on every write strobe and counts byte pulses.
  task automatic monitor();
    wr_rec_t e;
    forever begin
      @(negedge sys_clk);
      if (byte_valid) bv_count++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", wr_data, e.data);
        end
      end
    end
  endtask

  // Called at a negedge; returns at a negedge with the line idle high.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge sys_clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge sys_clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [31:0] d);
    wr_rec_t r;
    r.addr = a;
    r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic reload();
    load_en = 1'b0;
    repeat (4) @(negedge sys_clk);
    load_en = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    int bv_before;
    logic seen;

    for (int i = 0; i < 17; i++) begin
      vecs[i].data = {8'(i * 17 + 1), 8'(8'hA5 ^ i), 8'(i * 3), 8'(8'h3C + i)};
      vecs[i].addr = 4'(i % 16);
    end

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frameerror", 32'(frameerror), 32'd0);
    rst = 1'b0;
    fork
      monitor();
    join_none
    @(negedge sys_clk);

    // Single word
    load_en = 1'b1;
    repeat (4) @(negedge sys_clk);
    expect_write(4'd0, 32'h1234_5678);
    send_word(32'h1234_5678);
    wait_drain("single_drain");
    check("single_word_cnt", 32'(word_cnt), 32'd1);
    check("single_byte_data", 32'(byte_data), 32'h12);

    // 17 back-to-back words: address wraps, count saturates
    reload();
    bv_before = bv_count;
    for (int i = 0; i < 17; i++) begin
      expect_write(vecs[i].addr, vecs[i].data);
      send_word(vecs[i].data);
    end
    wait_drain("stream_drain");
    check("stream_word_cnt", 32'(word_cnt), 32'd16);
    check("stream_frameerror", 32'(frameerror), 32'd0);
    check("stream_byte_count", 32'(bv_count - bv_before), 32'd68);

    // Bad stop bit resyncs the word boundary
    reload();
    bv_before = bv_count;
    send_byte(8'h11, 1'b1);
    send_byte(8'hA5, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge sys_clk);
    check("ferr_flag", 32'(frameerror), 32'd1);
    check("ferr_byte_data", 32'(byte_data), 32'h11);
    expect_write(4'd0, 32'hDDCC_BBAA);
    send_word(32'hDDCC_BBAA);
    wait_drain("ferr_drain");
    check("ferr_byte_count", 32'(bv_count - bv_before), 32'd5);
    check("ferr_sticky", 32'(frameerror), 32'd1);
    reload();
    check("ferr_cleared", 32'(frameerror), 32'd0);

    // Short glitch is a false start
    bv_before = bv_count;
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (i == 2) rx = 1'b1;
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 32'd1);
    repeat (40) @(negedge sys_clk);
    check("glitch_busy_clear", 32'(busy), 32'd0);
    check("glitch_no_byte", 32'(bv_count - bv_before), 32'd0);
    check("glitch_no_ferr", 32'(frameerror), 32'd0);

    // load_en dropped mid bit 4 of the second byte of a word
    reload();
    expect_write(4'd0, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D);
    wait_drain("abort_pre_drain");
    check("abort_pre_cnt", 32'(word_cnt), 32'd1);
    send_byte(8'h3C, 1'b1);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 1);
      repeat (BIT_CLKS) @(negedge sys_clk);
    end
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge sys_clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    load_en = 1'b0;
    @(negedge sys_clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_word_cnt", 32'(word_cnt), 32'd0);
    repeat (20) @(negedge sys_clk);
    load_en = 1'b1;
    repeat (4) @(negedge sys_clk);
    expect_write(4'd0, 32'h4433_2211);
    send_word(32'h4433_2211);
    wait_drain("abort_post_drain");

    // Long idle gap after a partial word
    reload();
`ifdef UART_WORD_LOADER_TIMEOUT_EN
    expect_write(4'd0, 32'hC3C2_C1C0);
`else
    expect_write(4'd0, 32'hC1C0_B1B0);
`endif
    send_byte(8'hB0, 1'b1);
    send_byte(8'hB1, 1'b1);
    repeat (161 * BIT_CLKS) @(negedge sys_clk);
    send_word(32'hC3C2_C1C0);
    wait_drain("gap_drain");
    check("gap_word_cnt", 32'(word_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
